// File: rtl/rover_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rover_pkg                                                       |
// | Purpose  : Shared types and constants for the rover move sequencer:       |
// |            state encoding, move-word field positions, angle limits,       |
// |            motor direction levels and the turn decode helper.             |
// | Ports    : none (package)                                                 |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package rover_pkg;

  // Sequencer states; encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TURN   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DRIVE  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Move-word field positions.
  localparam int ANGLE_MSB = 11;
  localparam int ANGLE_LSB = 7;
  localparam int DIST_MSB  = 6;

  // Angle limits in 15 degree units.
  localparam logic [4:0] ANGLE_MAX = 5'd23;
  localparam logic [4:0] HALF_TURN = 5'd12;
  localparam logic [4:0] FULL_TURN = 5'd24;

  // Motor direction pin levels.
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef struct packed {
    logic       left;   // 1 = counter-clockwise turn
    logic [4:0] units;  // turn length in 15 degree units
  } turn_t;

  // Angles up to half a revolution turn left by the angle itself; larger
  // angles take the shorter way round, turning right by the complement.
  function automatic turn_t decode_turn(input logic [4:0] angle);
    turn_t t;
    if (angle <= HALF_TURN) begin
      t.left  = 1'b1;
      t.units = angle;
    end else begin
      t.left  = 1'b0;
      t.units = FULL_TURN - angle;
    end
    return t;
  endfunction

endpackage : rover_pkg
`default_nettype wire

// File: rtl/rover_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rover_tick_gen                                                  |
// | Purpose  : Motion tick prescaler. Produces a one-cycle tick every         |
// |            TICK_DIV clocks; a restart zeroes the prescaler so the next    |
// |            tick lands exactly TICK_DIV cycles later.                      |
// | Ports    : clock   - system clock                                         |
// |            reset   - synchronous, active-low reset                        |
// |            restart - zero the prescaler on the coming edge                |
// |            tick    - one-cycle motion tick                                |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rover_tick_gen
  import rover_pkg::*;
#(
  parameter int TICK_DIV = 27000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick is the last prescaler count, so it is seen during the TICK_DIV-th
  // cycle after a restart and consumed on the edge that closes it.
  assign tick = (cnt_q == CNT_LAST);

endmodule : rover_tick_gen
`default_nettype wire

// File: rtl/rover_move_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rover_move_sequencer                                            |
// | Purpose  : Runs the drive motors from decoded IR move words: turn in      |
// |            place, settle, drive forward, then report completion.          |
// | Ports    : clock, reset (sync, active-low)                                 |
// |            cmd_valid, cmd_data[11:0] - move word strobe / payload         |
// |              cmd_data[11:7] angle index (15 deg units, 0..23)             |
// |              cmd_data[6:0]  distance units (0..127)                       |
// |            motor_{l,r}_{en,dir}      - motor pins, dir 1 = forward        |
// |            busy, move_done, cmd_reject, state[2:0]                         |
// | Config   : ROVER_PENDING_EN - when defined, a one-deep pending register   |
// |            holds a command that arrives while a move is in progress.      |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rover_move_sequencer
  import rover_pkg::*;
#(
  parameter int          TICK_DIV     = 27000,
  parameter logic [15:0] TURN_TICKS   = 16'd40,
  parameter logic [15:0] DRIVE_TICKS  = 16'd25,
  parameter logic [15:0] SETTLE_TICKS = 16'd100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [11:0] cmd_data,
  output logic        motor_l_en,
  output logic        motor_l_dir,
  output logic        motor_r_en,
  output logic        motor_r_dir,
  output logic        busy,
  output logic        move_done,
  output logic        cmd_reject,
  output logic [2:0]  state
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e      state_q,      state_d;
  logic        turn_left_q,  turn_left_d;
  logic [4:0]  turn_units_q, turn_units_d;
  logic [6:0]  dist_q,       dist_d;
  logic [15:0] ticks_q,      ticks_d;
  logic [3:0]  motors_q,     motors_d;   // {l_en, l_dir, r_en, r_dir}
  logic        busy_q,       busy_d;
  logic        done_q,       done_d;
  logic        reject_q,     reject_d;
`ifdef ROVER_PENDING_EN
  logic        pend_valid_q, pend_valid_d;
  logic [11:0] pend_data_q,  pend_data_d;
  logic        pend_take;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic        tick;
  logic        restart;
  logic        exit_now;
  logic [15:0] target;
  logic        cmd_ok;
  logic        launch;
  logic [11:0] launch_word;
  turn_t       launch_turn;

  assign cmd_ok = cmd_valid && (cmd_data[ANGLE_MSB:ANGLE_LSB] <= ANGLE_MAX);

  rover_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // Tick target for the current state; products wrap at 16 bits.
  always_comb begin
    target = 16'd0;
    case (state_q)
      ST_TURN:   target = {11'd0, turn_units_q} * TURN_TICKS;
      ST_SETTLE: target = SETTLE_TICKS;
      ST_DRIVE:  target = {9'd0, dist_q} * DRIVE_TICKS;
      default:   target = 16'd0;
    endcase
  end

  // Leave on the tick that brings the count up to the target. A zero target
  // (only possible through a zero SETTLE_TICKS) leaves after one cycle.
  assign exit_now = (target == 16'd0) || (tick && ((ticks_q + 16'd1) == target));

  // ---------------------------------------------------------------------------
  // Next-state, decode and pending buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    turn_left_d  = turn_left_q;
    turn_units_d = turn_units_q;
    dist_d       = dist_q;
    reject_d     = 1'b0;
    launch       = 1'b0;
    launch_word  = cmd_data;
`ifdef ROVER_PENDING_EN
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_take    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef ROVER_PENDING_EN
        // A command left pending by a FINISH-cycle arrival goes first.
        if (pend_valid_q) begin
          pend_take    = 1'b1;
          pend_valid_d = 1'b0;
          launch       = 1'b1;
          launch_word  = pend_data_q;
        end else if (cmd_ok) begin
          launch = 1'b1;
        end
`else
        if (cmd_ok) begin
          launch = 1'b1;
        end
`endif
      end
      ST_TURN: begin
        if (exit_now) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (exit_now) state_d = (dist_q == 7'd0) ? ST_FINISH : ST_DRIVE;
      end
      ST_DRIVE: begin
        if (exit_now) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
`ifdef ROVER_PENDING_EN
        // Chain straight into the pending move without an IDLE cycle.
        if (pend_valid_q) begin
          pend_take    = 1'b1;
          pend_valid_d = 1'b0;
          launch       = 1'b1;
          launch_word  = pend_data_q;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Arrivals that are not launched this cycle.
    if (cmd_valid && !cmd_ok) begin
      reject_d = 1'b1;
`ifdef ROVER_PENDING_EN
    end else if (cmd_valid && ((state_q != ST_IDLE) || pend_take)) begin
      // Overwriting a still-held command discards it; if the held one is
      // being consumed this cycle, the newcomer simply takes its place.
      if (pend_valid_q && !pend_take) begin
        reject_d = 1'b1;
      end
      pend_valid_d = 1'b1;
      pend_data_d  = cmd_data;
    end
`else
    end else if (cmd_valid && (state_q != ST_IDLE)) begin
      reject_d = 1'b1;
    end
`endif

    launch_turn = decode_turn(launch_word[ANGLE_MSB:ANGLE_LSB]);
    if (launch) begin
      state_d      = (launch_word[ANGLE_MSB:ANGLE_LSB] == 5'd0) ? ST_SETTLE : ST_TURN;
      turn_left_d  = launch_turn.left;
      turn_units_d = launch_turn.units;
      dist_d       = launch_word[DIST_MSB:0];
    end

    // Outputs are decoded from the next state so they line up with it.
    case (state_d)
      ST_TURN:  motors_d = turn_left_d ? {1'b1, DIR_REV, 1'b1, DIR_FWD}
                                       : {1'b1, DIR_FWD, 1'b1, DIR_REV};
      ST_DRIVE: motors_d = {1'b1, DIR_FWD, 1'b1, DIR_FWD};
      default:  motors_d = 4'b0000;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  // Every state change is an entry: both the prescaler and the tick count
  // start over so each phase is timed from its own first cycle.
  assign restart = (state_d != state_q);

  always_comb begin
    ticks_d = ticks_q;
    if (restart || (state_q == ST_IDLE)) begin
      ticks_d = 16'd0;
    end else if (tick) begin
      ticks_d = ticks_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      turn_left_q  <= 1'b0;
      turn_units_q <= 5'd0;
      dist_q       <= 7'd0;
      ticks_q      <= 16'd0;
      motors_q     <= 4'b0000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
`ifdef ROVER_PENDING_EN
      pend_valid_q <= 1'b0;
      pend_data_q  <= 12'd0;
`endif
    end else begin
      state_q      <= state_d;
      turn_left_q  <= turn_left_d;
      turn_units_q <= turn_units_d;
      dist_q       <= dist_d;
      ticks_q      <= ticks_d;
      motors_q     <= motors_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      reject_q     <= reject_d;
`ifdef ROVER_PENDING_EN
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
`endif
    end
  end

  assign motor_l_en  = motors_q[3];
  assign motor_l_dir = motors_q[2];
  assign motor_r_en  = motors_q[1];
  assign motor_r_dir = motors_q[0];
  assign busy        = busy_q;
  assign move_done   = done_q;
  assign cmd_reject  = reject_q;
  assign state       = state_q;

endmodule : rover_move_sequencer
`default_nettype wire

// File: tb/tb_rover_move_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rover_move_sequencer                                         |
// | Purpose  : Directed self-checking bench for rover_move_sequencer with     |
// |            TICK_DIV=4, TURN_TICKS=2, DRIVE_TICKS=3, SETTLE_TICKS=1.       |
// |            Expectations for busy arrivals follow ROVER_PENDING_EN.        |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rover_move_sequencer;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic [11:0] cmd_data;
  logic       motor_l_en, motor_l_dir, motor_r_en, motor_r_dir;
  logic       busy, move_done, cmd_reject;
  logic [2:0] state;
  logic [3:0] motors_w;

  int checks;
  int errors;

  localparam logic [3:0] M_LEFT  = 4'b1011;
  localparam logic [3:0] M_RIGHT = 4'b1110;
  localparam logic [3:0] M_FWD   = 4'b1111;
  localparam logic [3:0] M_OFF   = 4'b0000;

  assign motors_w = {motor_l_en, motor_l_dir, motor_r_en, motor_r_dir};

  rover_move_sequencer #(
    .TICK_DIV     (4),
    .TURN_TICKS   (16'd2),
    .DRIVE_TICKS  (16'd3),
    .SETTLE_TICKS (16'd1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .motor_l_en  (motor_l_en),
    .motor_l_dir (motor_l_dir),
    .motor_r_en  (motor_r_en),
    .motor_r_dir (motor_r_dir),
    .busy        (busy),
    .move_done   (move_done),
    .cmd_reject  (cmd_reject),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One-cycle command strobe; returns on the negedge after the capture edge.
  task automatic send(input logic [11:0] word);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = word;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_data  = 12'd0;
  endtask

  // Checks the outputs on entry to a state, then counts its cycles.
  task automatic phase(input string tag, input logic [2:0] st, input logic [3:0] mot,
                       input int len);
    int n;
    chk({tag, "_state"},  32'(state),     32'(st));
    chk({tag, "_motors"}, 32'(motors_w),  32'(mot));
    chk({tag, "_busy"},   32'(busy),      32'd1);
    chk({tag, "_done"},   32'(move_done), (st == 3'd4) ? 32'd1 : 32'd0);
    n = 0;
    while ((state == st) && (n < 4000)) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_len"}, 32'(n), 32'(len));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    int n;
    n = 0;
    while ((state != st) && (n < 4000)) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_reach"}, 32'(state), 32'(st));
  endtask

  task automatic move(input string tag, input logic [11:0] word, input logic [3:0] tmot,
                      input int tlen, input int dlen);
    send(word);
    if (tlen != 0) phase({tag, "_turn"}, 3'd1, tmot, tlen);
    phase({tag, "_settle"}, 3'd2, M_OFF, 4);
    if (dlen != 0) phase({tag, "_drive"}, 3'd3, M_FWD, dlen);
    phase({tag, "_finish"}, 3'd4, M_OFF, 1);
    chk({tag, "_idle"},     32'(state),     32'd0);
    chk({tag, "_idlebusy"}, 32'(busy),      32'd0);
    chk({tag, "_idledone"}, 32'(move_done), 32'd0);
  endtask

  initial begin
    int n_done;
    int n_busy;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 12'd0;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst_state",  32'(state),      32'd0);
    chk("rst_motors", 32'(motors_w),   32'(M_OFF));
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_done",   32'(move_done),  32'd0);
    chk("rst_reject", 32'(cmd_reject), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Left 3 units (6 ticks = 24 cycles), settle 4, drive 5 units (60)
    move("left3", 12'b00011_0000101, M_LEFT, 24, 60);
    // Right 4 units (angle 20) = 32 cycles, no drive
    move("right20", {5'd20, 7'd0}, M_RIGHT, 32, 0);
    // Boundaries: angle 12 is the largest left turn, 13 the largest right
    move("left12",  {5'd12, 7'd0}, M_LEFT,  96, 0);
    move("right13", {5'd13, 7'd1}, M_RIGHT, 88, 12);
    move("right23", {5'd23, 7'd0}, M_RIGHT, 8,  0);
    // Angle 0 skips TURN entirely
    move("straight", {5'd0, 7'd2}, M_OFF, 0, 24);

    // Invalid angle in IDLE
    send({5'd24, 7'd3});
    chk("inv_reject",  32'(cmd_reject), 32'd1);
    chk("inv_state",   32'(state),      32'd0);
    chk("inv_motors",  32'(motors_w),   32'(M_OFF));
    chk("inv_busy",    32'(busy),       32'd0);
    @(negedge clock);
    chk("inv_pulse",   32'(cmd_reject), 32'd0);
    chk("inv_state2",  32'(state),      32'd0);

    // Busy arrivals: A = angle 1 dist 1, B during TURN, C = angle 0 dist 2 during DRIVE
    send({5'd1, 7'd1});
    chk("busyA_turn", 32'(state), 32'd1);
    repeat (2) @(negedge clock);
    send({5'd2, 7'd4});
`ifdef ROVER_PENDING_EN
    chk("busyB_reject", 32'(cmd_reject), 32'd0);
`else
    chk("busyB_reject", 32'(cmd_reject), 32'd1);
`endif
    wait_state("busyA_drive", 3'd3);
    send({5'd0, 7'd2});
    chk("busyC_reject", 32'(cmd_reject), 32'd1);
    @(negedge clock);
    chk("busyC_pulse",  32'(cmd_reject), 32'd0);
    wait_state("busyA_finish", 3'd4);
    phase("busyA_fin", 3'd4, M_OFF, 1);
`ifdef ROVER_PENDING_EN
    chk("busyC_chain_busy", 32'(busy), 32'd1);
    phase("busyC_settle", 3'd2, M_OFF, 4);
    phase("busyC_drive",  3'd3, M_FWD, 24);
    phase("busyC_finish", 3'd4, M_OFF, 1);
`endif
    chk("busy_end_state", 32'(state), 32'd0);
    chk("busy_end_busy",  32'(busy),  32'd0);

    // Reset during DRIVE
    send({5'd0, 7'd10});
    wait_state("rstmv_drive", 3'd3);
    repeat (3) @(negedge clock);
    chk("rstmv_pre_motors", 32'(motors_w), 32'(M_FWD));
    reset = 1'b0;
    @(negedge clock);
    chk("rstmv_state",  32'(state),     32'd0);
    chk("rstmv_motors", 32'(motors_w),  32'(M_OFF));
    chk("rstmv_busy",   32'(busy),      32'd0);
    chk("rstmv_done",   32'(move_done), 32'd0);
    reset = 1'b1;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (move_done) n_done++;
      if (busy) n_busy++;
    end
    chk("rstmv_no_done", 32'(n_done), 32'd0);
    chk("rstmv_no_busy", 32'(n_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rover_move_sequencer
`default_nettype wire

// File: doc/rover_move_sequencer.md
# rover_move_sequencer

Sequences the rover drive motors from decoded IR commands. Accepts the 12-bit move word and one-cycle `done` strobe produced by the rover IR receiver, splits it into a turn angle and a drive distance, and runs the motors: turn in place, settle, drive forward, then report completion. It sits between the IR receiver and the motor driver pins and is the only block that drives the motors.

## Interface
Parameters:
- `TICK_DIV`, 27000: clock cycles per motion tick (1 ms at 27 MHz).
- `TURN_TICKS`, 16'd40: ticks per 15° turn unit.
- `DRIVE_TICKS`, 16'd25: ticks per distance unit.
- `SETTLE_TICKS`, 16'd100: pause between turn and drive.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: one-cycle strobe, wired to IR receiver `done`.
- `cmd_data` in 12: `[11:7]` angle index in 15° units, valid range 0–23; `[6:0]` distance units, 0–127.
- `motor_l_en`, `motor_l_dir`, `motor_r_en`, `motor_r_dir` out 1 each: dir 1 = forward.
- `busy` out 1: high in any state other than IDLE.
- `move_done` out 1: one-cycle pulse when a move completes.
- `cmd_reject` out 1: one-cycle pulse when a command is discarded.
- `state` out 3: current state, for debug.

## Operation
- States: IDLE=0, TURN=1, SETTLE=2, DRIVE=3, FINISH=4.
- **Validation.** A command with angle > 23 is rejected: `cmd_reject` pulses and state is unchanged.
- **Decode on accept.**
  - angle 0: skip TURN and go straight to SETTLE.
  - angle 1–12: left (CCW) turn of `angle` units.
  - angle 13–23: right turn of `24−angle` units.
  - distance 0: skip DRIVE and go SETTLE→FINISH.
- **Tick counting.**
  - Tick target = units × per-unit ticks, 16-bit unsigned with no saturation. Parameters are sized so 127×`DRIVE_TICKS` < 65536.
  - The tick counter resets to 0 on every state entry.
  - The state exits on the tick where the count equals the target.
- **Motor outputs** are decoded from the state:
  - TURN left: L en/rev, R en/fwd.
  - TURN right: L en/fwd, R en/rev.
  - DRIVE: both en/fwd.
  - All other states: every `*_en`=0 and every `*_dir`=0.
- **FINISH** lasts one cycle and pulses `move_done`. It then returns to IDLE, or consumes the pending command (see Configuration).
- **Accepting while IDLE.** `cmd_valid` in IDLE with a valid command loads the angle and distance registers. The next state is TURN (or SETTLE if angle 0).
- **Tick generator.**
  - Free-running, divided by `TICK_DIV`.
  - Its prescaler restarts on every state entry, so the first tick comes `TICK_DIV` cycles after entry.

## Timing
- **Reset values:** state=IDLE; all motor outputs 0; `busy`, `move_done`, `cmd_reject` 0; pending buffer empty; counters 0.
- **Command to motion:** `cmd_valid` at cycle N. The state register shows TURN at N+1, and the motor outputs are valid at N+1 (registered).
- **TURN duration:** exactly units×`TURN_TICKS`×`TICK_DIV` cycles ±1.
- **`move_done`:** high for exactly one cycle. `busy` drops the cycle after it, unless a pending command is consumed, in which case `busy` stays high.
- **Reset mid-move:** motors are off on the next edge and there is no `move_done`.
- **`cmd_valid` during FINISH:** treated as a busy-state arrival (below), never lost silently.

## Configuration
- Macro: `ROVER_PENDING_EN`.
- **Defined:**
  - A one-deep pending register captures a valid command arriving while busy.
  - A newer valid arrival overwrites it and pulses `cmd_reject` for the overwritten command.
  - In FINISH, a full pending register moves directly to TURN/SETTLE; no IDLE cycle is inserted.
  - If the register is full and `cmd_valid` coincides with consumption, the new command becomes pending.
- **Undefined:** any `cmd_valid` while busy is dropped with a `cmd_reject` pulse.

## Structure
- **Package `rover_pkg`:**
  - State encoding constants.
  - Field constants: `ANGLE_MSB`=11, `ANGLE_LSB`=7, `DIST_MSB`=6, `ANGLE_MAX`=23, `HALF_TURN`=12.
  - Motor direction constants.
- **Sub-module `rover_tick_gen`:** prescaler with a `restart` input and a one-cycle `tick` output, parameter `TICK_DIV`.
- All remaining logic (FSM, decode, pending buffer) stays in this module.

## Test plan
Simulate with `TICK_DIV`=4, `TURN_TICKS`=2, `DRIVE_TICKS`=3, `SETTLE_TICKS`=1.
- **Left turn plus drive.** cmd 12'b00011_0000101 (angle 3, dist 5) → left turn for 24 cycles, settle for 4, drive fwd for 60, then a one-cycle `move_done` and IDLE.
- **Right turn, zero distance.** cmd angle 20, dist 0 → right turn for 4 units (32 cycles), settle, FINISH; no DRIVE state.
- **Invalid angle.** cmd angle 24 in IDLE → `cmd_reject` pulses one cycle; state stays IDLE; motors remain 0.
- **Busy arrivals, with macro.** Second cmd during TURN, third during DRIVE → one `cmd_reject`. The third command runs immediately after FINISH, and `busy` never drops.
- **Busy arrival, without macro.** Second cmd during DRIVE → `cmd_reject`; IDLE after the first move.
- **Reset mid-move.** `reset`=0 during DRIVE → next cycle all outputs 0 and state IDLE; no `move_done`.
